// File: rtl/spi_fifo_pkg.sv
// Shared SPI package: default FIFO geometry, a log2 helper for pointer and
// threshold widths, and the push/pop operation encoding used by the FIFO.
`timescale 1ns/1ps
package spi_fifo_pkg;

  // Default entry width and number of entries for the TX and RX FIFOs.
  localparam int SPI_DATA_WIDTH   = 32;
  localparam int SPI_BUFFER_DEPTH = 10;

  // Ceiling log2. Sizes a pointer that must address n entries.
  // Valid for n >= 2.
  function automatic int spi_log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Width of the register interface's FIFO level thresholds. They compare
  // against an occupancy count, which runs from 0 to the depth inclusive.
  localparam int SPI_THRESH_WIDTH = spi_log2(SPI_BUFFER_DEPTH) + 1;

  // Per-cycle FIFO operation, formed as {push, pop}.
  typedef enum logic [1:0] {
    FIFO_OP_IDLE = 2'b00,
    FIFO_OP_POP  = 2'b01,
    FIFO_OP_PUSH = 2'b10,
    FIFO_OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/spi_fifo_if.sv
// Stream bundle for one SPI FIFO instance: a push side, a pop side, a flush
// and the occupancy. The master modport is the producer/consumer agent. The
// slave modport is the FIFO itself.
`timescale 1ns/1ps
interface spi_fifo_if
  import spi_fifo_pkg::*;
#(
  parameter int DATA_WIDTH       = SPI_DATA_WIDTH,
  parameter int LOG_BUFFER_DEPTH = spi_log2(SPI_BUFFER_DEPTH)
);
  logic [DATA_WIDTH-1:0]     wdata;
  logic                      wvalid;
  logic                      wready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic                      rvalid;
  logic                      rready;
  logic                      clr;
  logic [LOG_BUFFER_DEPTH:0] elements;

  modport master (
    output wdata, wvalid, rready, clr,
    input  wready, rdata, rvalid, elements
  );

  modport slave (
    input  wdata, wvalid, rready, clr,
    output wready, rdata, rvalid, elements
  );
endinterface

// File: rtl/spi_fifo.sv
// Synchronous first-word-fall-through FIFO for the SPI TX and RX data paths.
// The depth can be any value and need not be a power of two, so both pointers
// wrap explicitly at depth-1. The full and empty flags decode only the
// registered count. No combinational path runs from valid_i or ready_i to an
// output.
`timescale 1ns/1ps
module spi_fifo
  import spi_fifo_pkg::*;
#(
  parameter int BUFFER_DEPTH     = SPI_BUFFER_DEPTH,
  parameter int DATA_WIDTH       = SPI_DATA_WIDTH,
  parameter int LOG_BUFFER_DEPTH = spi_log2(BUFFER_DEPTH)
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      clr_i,
  output logic [LOG_BUFFER_DEPTH:0] elements_o,
  input  logic [DATA_WIDTH-1:0]     data_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  output logic [DATA_WIDTH-1:0]     data_o,
  output logic                      valid_o,
  input  logic                      ready_i
);

  localparam logic [LOG_BUFFER_DEPTH-1:0] LAST_PTR = LOG_BUFFER_DEPTH'(BUFFER_DEPTH - 1);
  localparam logic [LOG_BUFFER_DEPTH:0]   FULL_CNT = (LOG_BUFFER_DEPTH + 1)'(BUFFER_DEPTH);

  logic [DATA_WIDTH-1:0]       mem_q [BUFFER_DEPTH];
  logic [LOG_BUFFER_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG_BUFFER_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG_BUFFER_DEPTH:0]   cnt_q, cnt_d;
  logic                        push_w;
  logic                        pop_w;
  fifo_op_e                    op_w;

  // Advance a pointer and wrap at the last real entry, not at the next
  // power of two.
  function automatic logic [LOG_BUFFER_DEPTH-1:0] ptr_inc(input logic [LOG_BUFFER_DEPTH-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Status flags come only from the registered count.
  assign ready_o    = (cnt_q != FULL_CNT);
  assign valid_o    = (cnt_q != '0);
  assign elements_o = cnt_q;
  assign data_o     = mem_q[rd_ptr_q];

  // Gate each request with the registered flag. A full FIFO ignores pushes,
  // even in a pop cycle. An empty FIFO ignores pops and never bypasses data.
  assign push_w = valid_i & ready_o;
  assign pop_w  = ready_i & valid_o;
  assign op_w   = fifo_op_e'({push_w, pop_w});

  // Next-state pointers and count. A flush overrides any concurrent push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      case (op_w)
        FIFO_OP_PUSH: begin
          wr_ptr_d = ptr_inc(wr_ptr_q);
          cnt_d    = cnt_q + 1'b1;
        end
        FIFO_OP_POP: begin
          rd_ptr_d = ptr_inc(rd_ptr_q);
          cnt_d    = cnt_q - 1'b1;
        end
        FIFO_OP_BOTH: begin
          wr_ptr_d = ptr_inc(wr_ptr_q);
          rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        default: begin
        end
      endcase
    end
  end

  // Pointer and count registers. Reset clears them immediately.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage entries. Reset clears every entry so that data_o reads zero.
  // A flush moves only the pointers and leaves the contents as they are.
  for (genvar gi = 0; gi < BUFFER_DEPTH; gi++) begin : g_entry
    localparam logic [LOG_BUFFER_DEPTH-1:0] ENTRY_IDX = LOG_BUFFER_DEPTH'(gi);

    // Capture push data when this entry is the write target.
    always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
        mem_q[gi] <= '0;
      end else if (push_w && !clr_i && (wr_ptr_q == ENTRY_IDX)) begin
        mem_q[gi] <= data_i;
      end
    end
  end

endmodule

// File: tb/tb_spi_fifo.sv
// Randomised and directed bench for spi_fifo. When the stimulus issues an
// accepted push, it appends the word to an expected queue and keeps an
// arithmetic occupancy model. A negedge monitor compares the status outputs
// and the head word against that model, and pops the queue whenever the DUT
// pops.
`timescale 1ns/1ps
module tb_spi_fifo;
  import spi_fifo_pkg::*;

  localparam int DEPTH = 10;
  localparam int DW    = 32;
  localparam int LW    = spi_log2(DEPTH);

  logic HCLK;
  logic HRESET;

  spi_fifo_if #(.DATA_WIDTH(DW), .LOG_BUFFER_DEPTH(LW)) bus ();

  spi_fifo #(.BUFFER_DEPTH(DEPTH), .DATA_WIDTH(DW), .LOG_BUFFER_DEPTH(LW)) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .clr_i      (bus.clr),
    .elements_o (bus.elements),
    .data_i     (bus.wdata),
    .valid_i    (bus.wvalid),
    .ready_o    (bus.wready),
    .data_o     (bus.rdata),
    .valid_o    (bus.rvalid),
    .ready_i    (bus.rready)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic [DW-1:0] exp_q[$];
  int            mdl_count;
  int            exp_cnt_now;
  bit            mon_en;
  int            n_checks;
  int            n_pass;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // One stimulus cycle. Drive just after the edge, then update the model as
  // the next edge will see it.
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic r, input logic c);
    @(posedge HCLK);
    #1;
    bus.wvalid = v;
    bus.wdata  = d;
    bus.rready = r;
    bus.clr    = c;
    exp_cnt_now = mdl_count;
    if (c) begin
      exp_q.delete();
      mdl_count = 0;
    end else begin
      if (v && (mdl_count < DEPTH)) begin
        exp_q.push_back(d);
        mdl_count++;
      end
      if (r && (exp_cnt_now > 0)) mdl_count--;
    end
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  // Monitor: check the status against the model. Check the head word whenever
  // the DUT shows valid data, and retire it when the DUT pops it.
  always @(negedge HCLK) begin
    if (mon_en) begin
      chk("elements_o", 64'(bus.elements), 64'(exp_cnt_now));
      chk("valid_o", 64'(bus.rvalid), 64'(exp_cnt_now != 0));
      chk("ready_o", 64'(bus.wready), 64'(exp_cnt_now != DEPTH));
      if (bus.rvalid && !bus.clr) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL data_o: got %0h with valid_o high, required no valid data", bus.rdata);
        end else begin
          chk("data_o", 64'(bus.rdata), 64'(exp_q[0]));
          if (bus.rready) begin
            $display("pop  data=%08h count_before=%0d", bus.rdata, exp_cnt_now);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0; n_pass = 0; mon_en = 0;
    mdl_count = 0; exp_cnt_now = 0;
    bus.wvalid = 0; bus.wdata = '0; bus.rready = 0; bus.clr = 0;
    HRESET = 1'b1;

    // Reset state
    @(posedge HCLK); #2;
    chk("rst_elements", 64'(bus.elements), 64'd0);
    chk("rst_valid", 64'(bus.rvalid), 64'd0);
    chk("rst_ready", 64'(bus.wready), 64'd1);
    chk("rst_data", 64'(bus.rdata), 64'd0);
    @(negedge HCLK);
    HRESET = 1'b0;
    mon_en = 1;

    // Three pushes with no pop, then three pops in order
    drive(1, 32'h11, 0, 0);
    drive(1, 32'h22, 0, 0);
    drive(1, 32'h33, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, '0, 1, 0);
    idle();

    // Fill to depth. An 11th push is dropped.
    for (int i = 0; i < DEPTH; i++) drive(1, 32'hA0 + 32'(i), 0, 0);
    drive(1, 32'hFF, 0, 0);
    // Full with push and pop together: only the pop happens.
    drive(1, 32'hEE, 1, 0);
    for (int i = 0; i < DEPTH; i++) drive(0, '0, 1, 0);
    idle();

    // Steady push/pop at count 5 across two pointer wraps
    for (int i = 0; i < 5; i++) drive(1, $urandom, 0, 0);
    for (int i = 0; i < 25; i++) drive(1, $urandom, 1, 0);
    for (int i = 0; i < 5; i++) drive(0, '0, 1, 0);
    idle();

    // Flush at count 4 with a concurrent push
    for (int i = 0; i < 4; i++) drive(1, 32'hC0 + 32'(i), 0, 0);
    drive(1, 32'hCC, 1, 1);
    idle();
    idle();

    // Asynchronous reset in mid-cycle at count 7
    for (int i = 0; i < 7; i++) drive(1, 32'hD0 + 32'(i), 0, 0);
    @(posedge HCLK); #1;
    bus.wvalid = 0; bus.rready = 0;
    #2;
    mon_en = 0;
    HRESET = 1'b1;
    #1;
    chk("arst_elements", 64'(bus.elements), 64'd0);
    chk("arst_data", 64'(bus.rdata), 64'd0);
    chk("arst_valid", 64'(bus.rvalid), 64'd0);
    chk("arst_ready", 64'(bus.wready), 64'd1);
    #2;
    HRESET = 1'b0;
    exp_q.delete();
    mdl_count = 0;
    exp_cnt_now = 0;
    mon_en = 1;
    drive(1, 32'h5A, 0, 0);
    drive(0, '0, 1, 0);
    idle();

    // Random traffic: push-heavy, then pop-heavy, then balanced, with rare flushes
    for (int i = 0; i < 450; i++) begin
      int pv, pr;
      pv = (i < 150) ? 75 : (i < 300) ? 25 : 50;
      pr = (i < 150) ? 25 : (i < 300) ? 75 : 50;
      drive(1'($urandom_range(0, 99) < pv), $urandom, 1'($urandom_range(0, 99) < pr),
            1'($urandom_range(0, 39) == 0));
    end
    for (int i = 0; i < DEPTH + 2; i++) drive(0, '0, 1, 0);
    idle();
    idle();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_fifo.md
SPI_FIFO -- requirements
Module: spi_fifo

Interface
REQ-001 SHALL have parameter BUFFER_DEPTH, default 10, meaning the number of storage entries (any integer 2..1024, not limited to powers of two).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the entry width.
REQ-003 SHALL have parameter LOG_BUFFER_DEPTH, default log2(BUFFER_DEPTH) from the shared package (4 for depth 10), meaning the pointer width; count width is LOG_BUFFER_DEPTH+1.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, with ports named HCLK and HRESET.
REQ-005 Ports SHALL be:
 HCLK  input  1  clock, all state on rising edge
 HRESET  input  1  asynchronous active-high reset
 clr_i  input  1  synchronous flush
 elements_o  output  LOG_BUFFER_DEPTH+1  current occupancy
 data_i  input  DATA_WIDTH  push data
 valid_i  input  1  push request
 ready_o  output  1  push accepted when high (not full)
 data_o  output  DATA_WIDTH  head entry
 valid_o  output  1  head valid (not empty)
 ready_i  input  1  pop request

Function
REQ-006 Push SHALL occur on a rising edge when valid_i && ready_o; pop SHALL occur when valid_o && ready_i.
REQ-007 ready_o SHALL equal (elements_o != BUFFER_DEPTH); valid_o SHALL equal (elements_o != 0); both SHALL be purely registered-state decodes with no combinational path from valid_i/ready_i.
REQ-008 data_o SHALL be the entry at the read pointer (first-word fall-through); a pushed word SHALL appear on data_o/valid_o one cycle after the push edge when the FIFO was empty.
REQ-009 The write and read pointers SHALL each increment on push and pop respectively, and wrap from BUFFER_DEPTH-1 to 0 (not at 2^LOG_BUFFER_DEPTH).
REQ-010 elements_o SHALL be +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
REQ-011 When full, valid_i SHALL be ignored, including in a pop cycle (no write-through); when full with ready_i high, only the pop occurs and the count drops to BUFFER_DEPTH-1.
REQ-012 When empty, ready_i SHALL be ignored; a push in the same cycle SHALL NOT be bypassed to data_o.
REQ-013 When clr_i is high, the next edge SHALL zero both pointers and elements_o, overriding any concurrent push or pop; storage contents are left unchanged.
REQ-014 Order SHALL be strictly first-in first-out; no entry is lost or duplicated across pointer wrap.

Reset
REQ-015 HRESET high SHALL immediately set the pointers to 0, elements_o to 0, valid_o to 0, ready_o to 1, and every storage entry (hence data_o) to 0.
REQ-016 HRESET asserted mid-transfer SHALL discard all contents; the first push after deassertion SHALL read back correctly.

Structure
REQ-017 The log2 depth helper and the default DATA_WIDTH/BUFFER_DEPTH constants SHALL live in the shared spi package, which the register interface also uses for its threshold widths.
REQ-018 The block SHALL be a single module with no sub-modules; one instance is used for TX (fed by the register interface's tx data/valid/ready) and one for RX (drained by its rx data/valid/ready).

Verification
REQ-019 Reset, then push 0x11,0x22,0x33 with ready_i=0 -> elements_o=3, data_o=0x11; then pop 3 times -> 0x11,0x22,0x33 in order, then valid_o=0.
REQ-020 Push 10 words 0xA0..0xA9 (depth 10) -> ready_o=0 at count 10; an 11th push of 0xFF is dropped; 10 pops return 0xA0..0xA9.
REQ-021 With the FIFO full, hold valid_i=1 and ready_i=1 for one cycle -> one pop, no push, elements_o=9.
REQ-022 Run 25 push/pop cycles at count 5 with valid_i=ready_i=1 (pointers wrap twice) -> elements_o stays 5 and the output sequence equals the input sequence.
REQ-023 At count 4, assert clr_i together with valid_i=1 -> next cycle elements_o=0, valid_o=0, ready_o=1.
REQ-024 Assert HRESET asynchronously mid-cycle at count 7 -> elements_o=0 and data_o=0 before the next edge; after release, push 0x5A and pop -> 0x5A.
